// File: rtl/top_level_asic.sv
// -----------------------------------------------------------------------------
// top_level_asic
// Single-operand Fibonacci engine. After reset is released it computes
// v0 = fib(a0_init) by pushing k = n, n-1 .. 2 onto an internal stack and then
// popping them back off. This mirrors the unwinding of a recursive evaluation.
// Each pop advances the pair (v0, a1) by one Fibonacci step.
//
// Ports:
//   clk          system clock, rising edge
//   reset_button asynchronous active-low reset (the only reset)
//   a0_init      operand n (unsigned); sampled only in the LOAD state
//   v0           result; shows intermediate values while busy
//   done         high once v0 holds fib(n); held until the next reset
// -----------------------------------------------------------------------------
module top_level_asic #(
   parameter int WIDTH       = 32,
   parameter int STACK_DEPTH = 32
) (
   input  logic             clk,
   input  logic             reset_button,
   input  logic [WIDTH-1:0] a0_init,
   output logic [WIDTH-1:0] v0,
   output logic             done
);

   localparam int               SP_W  = $clog2(STACK_DEPTH + 1);
   localparam logic [WIDTH-1:0] N_MAX = WIDTH'(STACK_DEPTH + 1);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      PUSH = 2'd1,
      POP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] n_reg;
   logic [WIDTH-1:0] k_reg;
   logic [WIDTH-1:0] a1_reg;
   logic [WIDTH-1:0] v0_reg;
   logic [SP_W-1:0]  sp_reg;
   logic             done_reg;

   logic [WIDTH-1:0] n_load;
   logic [SP_W-1:0]  sp_m1;
   logic [WIDTH-1:0] pop_val;
   logic [STACK_DEPTH-1:0][WIDTH-1:0] stack_q;

   // Clamp keeps the push count within the stack depth.
   assign n_load = (a0_init > N_MAX) ? N_MAX : a0_init;
   assign sp_m1  = sp_reg - SP_W'(1);

   // Stack storage: one register per entry. Each entry is written on a push
   // at its index, and cleared on the pop that reads it.
   generate
      for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
         logic [WIDTH-1:0] entry_reg;

         always_ff @(posedge clk or negedge reset_button) begin
            if (!reset_button) begin
               entry_reg <= '0;
            end else if (state_reg == PUSH && sp_reg == SP_W'(gi)) begin
               entry_reg <= k_reg;
            end else if (state_reg == POP && sp_m1 == SP_W'(gi)) begin
               entry_reg <= '0;
            end
         end

         assign stack_q[gi] = entry_reg;
      end
   endgenerate

   // Top-of-stack read. When sp is 0, sp-1 wraps past every index and the
   // result is zero; that case only occurs outside POP.
   always_comb begin
      pop_val = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (sp_m1 == SP_W'(i)) begin
            pop_val = stack_q[i];
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         LOAD: state_next = (n_load < WIDTH'(2)) ? DONE : PUSH;
         PUSH: if (k_reg == WIDTH'(2)) state_next = POP;
         // The bottom entry holds n, so popping it ends the unwind.
         POP:  if (pop_val == n_reg) state_next = DONE;
         DONE: state_next = DONE;
         default: state_next = LOAD;
      endcase
   end

   // State register and datapath
   always_ff @(posedge clk or negedge reset_button) begin
      if (!reset_button) begin
         state_reg <= LOAD;
         n_reg     <= '0;
         k_reg     <= '0;
         a1_reg    <= '0;
         v0_reg    <= '0;
         sp_reg    <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= (state_next == DONE);
         case (state_reg)
            LOAD: begin
               n_reg <= n_load;
               if (n_load == '0) begin
                  v0_reg <= '0;
               end else if (n_load == WIDTH'(1)) begin
                  v0_reg <= WIDTH'(1);
               end else begin
                  k_reg  <= n_load;
                  v0_reg <= WIDTH'(1);
                  a1_reg <= '0;
               end
            end
            PUSH: begin
               sp_reg <= sp_reg + SP_W'(1);
               k_reg  <= k_reg - WIDTH'(1);
            end
            POP: begin
               sp_reg <= sp_m1;
               v0_reg <= v0_reg + a1_reg;
               a1_reg <= v0_reg;
            end
            default: ;
         endcase
      end
   end

   assign v0   = v0_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_top_level_asic.sv
// -----------------------------------------------------------------------------
// tb_top_level_asic
// Directed and random runs of the Fibonacci engine. The expected results come
// from a plain iterative Fibonacci calculation and the closed-form latency
// (1 edge for n<2, 2n-1 edges otherwise, with n clamped to 33).
// -----------------------------------------------------------------------------
module tb_top_level_asic;

   localparam int WIDTH       = 32;
   localparam int STACK_DEPTH = 32;

   logic             clk;
   logic             reset_button;
   logic [WIDTH-1:0] a0_init;
   logic [WIDTH-1:0] v0;
   logic             done;

   int total_checks;
   int passed_checks;

   top_level_asic #(.WIDTH(WIDTH), .STACK_DEPTH(STACK_DEPTH)) dut (
      .clk          (clk),
      .reset_button (reset_button),
      .a0_init      (a0_init),
      .v0           (v0),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int eff_n(input int n);
      return (n > STACK_DEPTH + 1) ? STACK_DEPTH + 1 : n;
   endfunction

   function automatic logic [WIDTH-1:0] fib_ref(input int n);
      logic [WIDTH-1:0] a, b, t;
      a = '0;
      b = 1;
      for (int i = 0; i < eff_n(n); i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic int lat_ref(input int n);
      return (eff_n(n) < 2) ? 1 : 2 * eff_n(n) - 1;
   endfunction

   task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                        input logic [WIDTH-1:0] exp);
      total_checks++;
      assert (obs === exp) begin
         passed_checks++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Assert reset, set the operand, and release on a falling edge so that the
   // next rising edge is edge 1.
   task automatic start_run(input int n);
      @(negedge clk);
      reset_button = 1'b0;
      a0_init      = WIDTH'(n);
      #1;
      check("reset_v0", v0, '0);
      check("reset_done", {31'd0, done}, '0);
      @(negedge clk);
      reset_button = 1'b1;
   endtask

   // Step through the expected latency: done must stay low before the final
   // edge, then v0 must hold the result and remain frozen afterwards.
   task automatic run_and_check(input int n, input int change_edge,
                                input int new_op, input int stable_cycles);
      int lat;
      int early;
      lat   = lat_ref(n);
      early = 0;
      start_run(n);
      for (int e = 1; e <= lat; e++) begin
         @(posedge clk);
         #1;
         if (e == change_edge) a0_init = WIDTH'(new_op);
         if (e < lat && done !== 1'b0) early++;
      end
      check($sformatf("n%0d_early_done", n), WIDTH'(early), '0);
      check($sformatf("n%0d_done", n), {31'd0, done}, 32'd1);
      check($sformatf("n%0d_v0", n), v0, fib_ref(n));
      $display("run n=%0d latency=%0d v0=%0d done=%0b", n, lat, v0, done);
      if (stable_cycles > 0) begin
         a0_init = WIDTH'($urandom);
         repeat (stable_cycles) @(posedge clk);
         #1;
         check($sformatf("n%0d_stable_v0", n), v0, fib_ref(n));
         check($sformatf("n%0d_stable_done", n), {31'd0, done}, 32'd1);
      end
   endtask

   initial begin
      int n;
      total_checks  = 0;
      passed_checks = 0;
      reset_button  = 1'b1;
      a0_init       = '0;

      // Directed cases
      run_and_check(8, 0, 0, 20);
      run_and_check(0, 0, 0, 3);
      run_and_check(1, 0, 0, 3);
      run_and_check(2, 0, 0, 3);
      run_and_check(20, 0, 0, 3);
      run_and_check(33, 0, 0, 3);
      run_and_check(40, 0, 0, 3);

      // Operand change while busy is ignored
      run_and_check(8, 5, 3, 3);

      // Asynchronous reset mid-run, then a fresh run with n=5
      start_run(20);
      repeat (10) @(posedge clk);
      #1;
      reset_button = 1'b0;
      #1;
      check("midreset_v0", v0, '0);
      check("midreset_done", {31'd0, done}, '0);
      $display("mid-run reset: v0=%0d done=%0b", v0, done);
      run_and_check(5, 0, 0, 3);

      // Random operands, including values beyond the clamp
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(0, 45);
         run_and_check(n, (r % 2 == 1) ? 3 : 0, $urandom_range(0, 45), 2);
      end

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
